// File: rtl/cmos_pixel_assembler_if.sv
// Camera byte stream in, tagged RGB565 pixels and frame status out.
// pix_skin exists only when CMOS_SKIN_MASK_EN is defined.
interface cmos_pixel_assembler_if;
    logic        cap_en;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_data;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;
    logic        frame_done;
    logic        frame_ok;
    logic        err_odd;
    logic        err_size;
`ifdef CMOS_SKIN_MASK_EN
    logic        pix_skin;
`endif

    modport slave (
        input  cap_en,
        input  cmos_vsync,
        input  cmos_href,
        input  cmos_data,
        output pix_valid,
        output pix_data,
        output pix_x,
        output pix_y,
        output frame_start,
        output frame_done,
        output frame_ok,
        output err_odd,
        output err_size
`ifdef CMOS_SKIN_MASK_EN
        ,
        output pix_skin
`endif
    );

    modport master (
        output cap_en,
        output cmos_vsync,
        output cmos_href,
        output cmos_data,
        input  pix_valid,
        input  pix_data,
        input  pix_x,
        input  pix_y,
        input  frame_start,
        input  frame_done,
        input  frame_ok,
        input  err_odd,
        input  err_size
`ifdef CMOS_SKIN_MASK_EN
        ,
        input  pix_skin
`endif
    );
endinterface

// File: rtl/cmos_pixel_assembler.sv
// Pairs camera bytes into RGB565 pixels tagged with x/y, with frame markers and error flags.
// Defining CMOS_SKIN_MASK_EN adds the pix_skin output, registered alongside pix_data.
module cmos_pixel_assembler #(
    parameter int         H_ACTIVE  = 640,
    parameter int         V_ACTIVE  = 480,
    parameter bit         BYTE_SWAP = 1'b0
`ifdef CMOS_SKIN_MASK_EN
    ,
    parameter logic [4:0] SKIN_RMIN = 5'd12
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    cmos_pixel_assembler_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_ACTIVE} state_t;

    localparam logic [9:0] H_LIM   = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM   = 10'(V_ACTIVE);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

`ifdef CMOS_SKIN_MASK_EN
    function automatic logic skin_test(input logic [15:0] px);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = px[15:11];
        g = px[10:5];
        b = px[4:0];
        return (r >= SKIN_RMIN) && (r > g[5:1]) && (r > b);
    endfunction
`endif

    state_t      r_state;
    logic        r_vsync_p0;
    logic        r_vsync_p1;
    logic        r_href_p0;
    logic        r_href_p1;
    logic [7:0]  r_data_p0;
    logic [7:0]  r_hold_p1;
    logic        r_phase;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_err_odd;
    logic        r_err_size;
    logic        r_vld_p1;
    logic [15:0] r_pix_p1;
    logic [9:0]  r_pix_x;
    logic [9:0]  r_pix_y;
    logic        r_frame_start;
    logic        r_frame_done;
    logic        r_frame_ok;
`ifdef CMOS_SKIN_MASK_EN
    logic        r_skin_p1;
`endif

    logic        w_vs_rise;
    logic        w_vs_fall;
    logic        w_href_fall;
    logic        w_line_end;
    logic        w_store;
    logic        w_in_bounds;
    logic [15:0] w_pix_word;
    logic        w_err_odd_nxt;
    logic        w_err_size_nxt;
    logic [9:0]  w_y_nxt;
    logic        w_frame_ok;

    assign w_vs_rise   = r_vsync_p0 & ~r_vsync_p1;
    assign w_vs_fall   = ~r_vsync_p0 & r_vsync_p1;
    assign w_href_fall = ~r_href_p0 & r_href_p1;
    assign w_line_end  = (r_state == ST_ACTIVE) && w_href_fall;
    assign w_store     = (r_state == ST_ACTIVE) && r_href_p0 && !r_phase;
    assign w_in_bounds = (r_x < H_LIM) && (r_y < V_LIM);
    assign w_pix_word  = BYTE_SWAP ? {r_data_p0, r_hold_p1} : {r_hold_p1, r_data_p0};

    // Line-end effects resolved combinationally so a coincident vsync rise sees them.
    always_comb begin
        w_err_odd_nxt  = r_err_odd;
        w_err_size_nxt = r_err_size;
        w_y_nxt        = r_y;
        if (w_line_end) begin
            if (r_phase) begin
                w_err_odd_nxt = 1'b1;
            end
            if (r_x != H_LIM) begin
                w_err_size_nxt = 1'b1;
            end
            if (r_x != 10'd0) begin
                w_y_nxt = sat_inc(r_y);
            end
        end
    end

    assign w_frame_ok = (w_y_nxt == V_LIM) && !w_err_odd_nxt && !w_err_size_nxt;

    // Stage p0: raw byte capture; p1: first byte of the pair held for pixel assembly.
    always_ff @(posedge clk) begin
        r_data_p0 <= bus.cmos_data;
        if (w_store) begin
            r_hold_p1 <= r_data_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_vsync_p0    <= 1'b0;
            r_vsync_p1    <= 1'b0;
            r_href_p0     <= 1'b0;
            r_href_p1     <= 1'b0;
            r_phase       <= 1'b0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_err_odd     <= 1'b0;
            r_err_size    <= 1'b0;
            r_vld_p1      <= 1'b0;
            r_pix_p1      <= 16'd0;
            r_pix_x       <= 10'd0;
            r_pix_y       <= 10'd0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_ok    <= 1'b0;
`ifdef CMOS_SKIN_MASK_EN
            r_skin_p1     <= 1'b0;
`endif
        end else begin
            r_vsync_p0    <= bus.cmos_vsync;
            r_vsync_p1    <= r_vsync_p0;
            r_href_p0     <= bus.cmos_href;
            r_href_p1     <= r_href_p0;
            r_vld_p1      <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_vs_rise) begin
                        r_state <= ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    if (w_vs_fall && bus.cap_en) begin
                        r_state       <= ST_ACTIVE;
                        r_frame_start <= 1'b1;
                        r_x           <= 10'd0;
                        r_y           <= 10'd0;
                        r_phase       <= 1'b0;
                        r_err_odd     <= 1'b0;
                        r_err_size    <= 1'b0;
                    end
                end

                ST_ACTIVE: begin
                    r_y        <= w_y_nxt;
                    r_err_odd  <= w_err_odd_nxt;
                    r_err_size <= w_err_size_nxt;

                    if (w_line_end) begin
                        r_x     <= 10'd0;
                        r_phase <= 1'b0;
                    end else if (r_href_p0) begin
                        r_phase <= ~r_phase;
                        if (r_phase) begin
                            r_x <= sat_inc(r_x);
                            if (w_in_bounds) begin
                                r_vld_p1 <= 1'b1;
                                r_pix_p1 <= w_pix_word;
                                r_pix_x  <= r_x;
                                r_pix_y  <= r_y;
`ifdef CMOS_SKIN_MASK_EN
                                r_skin_p1 <= skin_test(w_pix_word);
`endif
                            end else begin
                                r_err_size <= 1'b1;
                            end
                        end
                    end

                    // A short frame is a line-count error too.
                    if (w_vs_rise) begin
                        r_state      <= ST_SYNC;
                        r_frame_done <= 1'b1;
                        r_frame_ok   <= w_frame_ok;
                        if (w_y_nxt != V_LIM) begin
                            r_err_size <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pix_valid   = r_vld_p1;
    assign bus.pix_data    = r_pix_p1;
    assign bus.pix_x       = r_pix_x;
    assign bus.pix_y       = r_pix_y;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_ok    = r_frame_ok;
    assign bus.err_odd     = r_err_odd;
    assign bus.err_size    = r_err_size;
`ifdef CMOS_SKIN_MASK_EN
    assign bus.pix_skin    = r_skin_p1;
`endif
endmodule

// File: tb/tb_cmos_pixel_assembler.sv
// Scoreboard bench for cmos_pixel_assembler: two instances (BYTE_SWAP 0 and 1) share one stimulus.
module tb_cmos_pixel_assembler;
    localparam int H = 4;
    localparam int V = 2;

    typedef struct packed {
        logic [15:0] d;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cyc = 32'd0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_fstart = 0;
    int          n_fdone = 0;
    logic        last_ok;
    logic        last_odd;
    logic        last_size;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  b;
    logic [7:0]  prev;
    int          m_y;
    bit          m_cap;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    cmos_pixel_assembler_if bus0();
    cmos_pixel_assembler_if bus1();

    assign bus1.cap_en     = bus0.cap_en;
    assign bus1.cmos_vsync = bus0.cmos_vsync;
    assign bus1.cmos_href  = bus0.cmos_href;
    assign bus1.cmos_data  = bus0.cmos_data;

    cmos_pixel_assembler #(.H_ACTIVE(H), .V_ACTIVE(V), .BYTE_SWAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    cmos_pixel_assembler #(.H_ACTIVE(H), .V_ACTIVE(V), .BYTE_SWAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    always @(negedge clk) begin : mon0
        exp_t e;
        if (bus0.pix_valid) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL pix0_unexpected: got data=%h x=%0d y=%0d, required no strobe",
                         bus0.pix_data, bus0.pix_x, bus0.pix_y);
            end else begin
                e = q0.pop_front();
                if (bus0.pix_data !== e.d) begin
                    n_bad++;
                    $display("FAIL pix0_data: got %h required %h", bus0.pix_data, e.d);
                end
                n_cmp++;
                if (bus0.pix_x !== e.x) begin
                    n_bad++;
                    $display("FAIL pix0_x: got %0d required %0d", bus0.pix_x, e.x);
                end
                n_cmp++;
                if (bus0.pix_y !== e.y) begin
                    n_bad++;
                    $display("FAIL pix0_y: got %0d required %0d", bus0.pix_y, e.y);
                end
                n_cmp++;
                if ((cyc - e.cyc) !== 32'd2) begin
                    n_bad++;
                    $display("FAIL pix0_latency: got %0d required 2", cyc - e.cyc);
                end
            end
        end
        if (bus0.frame_start) n_fstart++;
        if (bus0.frame_done) begin
            n_fdone++;
            last_ok   = bus0.frame_ok;
            last_odd  = bus0.err_odd;
            last_size = bus0.err_size;
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (bus1.pix_valid) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL pix1_unexpected: got data=%h, required no strobe", bus1.pix_data);
            end else begin
                e = q1.pop_front();
                if (bus1.pix_data !== e.d || bus1.pix_x !== e.x || bus1.pix_y !== e.y) begin
                    n_bad++;
                    $display("FAIL pix1_swap: got %h@(%0d,%0d) required %h@(%0d,%0d)",
                             bus1.pix_data, bus1.pix_x, bus1.pix_y, e.d, e.x, e.y);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_byte(input int k);
        exp_t e;
        tick();
        bus0.cmos_href = 1'b1;
        bus0.cmos_data = b;
        if ((k % 2) == 1 && m_cap && (k / 2) < H && m_y < V) begin
            e.d = {prev, b};
            e.x = 10'(k / 2);
            e.y = 10'(m_y);
            e.cyc = cyc;
            q0.push_back(e);
            e.d = {b, prev};
            q1.push_back(e);
        end
        prev = b;
        b = b + 8'h22;
    endtask

    task automatic send_line(input int nbytes, input bit vs_at_end);
        for (int k = 0; k < nbytes; k++) drive_byte(k);
        tick();
        bus0.cmos_href = 1'b0;
        if (vs_at_end) bus0.cmos_vsync = 1'b1;
        if (nbytes >= 2) m_y++;
        if (!vs_at_end) idle(3);
    endtask

    task automatic start_frame(input bit cap, input bit exp_start);
        int s;
        tick();
        bus0.cmos_vsync = 1'b1;
        bus0.cap_en = cap;
        idle(3);
        s = n_fstart;
        tick();
        bus0.cmos_vsync = 1'b0;
        idle(4);
        n_cmp++;
        if ((n_fstart - s) != (exp_start ? 1 : 0)) begin
            n_bad++;
            $display("FAIL frame_start: got %0d pulses required %0d", n_fstart - s, exp_start ? 1 : 0);
        end
        m_y = 0;
        m_cap = exp_start;
    endtask

    task automatic end_frame(input string name, input bit exp_done, input bit exp_ok,
                             input bit exp_odd, input bit exp_size);
        int s;
        bit seen;
        s = n_fdone;
        seen = 1'b0;
        bus0.cmos_vsync = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (n_fdone != s) seen = 1'b1;
        end
        n_cmp++;
        if (seen != exp_done) begin
            n_bad++;
            $display("FAIL %s_frame_done: got %0d required %0d", name, seen, exp_done);
        end
        if (exp_done && seen) begin
            n_cmp++;
            if (last_ok !== exp_ok) begin
                n_bad++;
                $display("FAIL %s_frame_ok: got %b required %b", name, last_ok, exp_ok);
            end
            n_cmp++;
            if (last_odd !== exp_odd) begin
                n_bad++;
                $display("FAIL %s_err_odd: got %b required %b", name, last_odd, exp_odd);
            end
            n_cmp++;
            if (last_size !== exp_size) begin
                n_bad++;
                $display("FAIL %s_err_size: got %b required %b", name, last_size, exp_size);
            end
        end
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL %s_pending: got %0d/%0d pixels outstanding required 0", name, q0.size(), q1.size());
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.cap_en = 1'b1;
        bus0.cmos_vsync = 1'b0;
        bus0.cmos_href = 1'b0;
        bus0.cmos_data = 8'h00;
        idle(3);
        n_cmp++;
        if (bus0.pix_valid !== 1'b0 || bus0.pix_data !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_pix: got vld=%b data=%h required 0/0000", bus0.pix_valid, bus0.pix_data);
        end
        n_cmp++;
        if (bus0.pix_x !== 10'd0 || bus0.pix_y !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_xy: got %0d/%0d required 0/0", bus0.pix_x, bus0.pix_y);
        end
        n_cmp++;
        if (bus0.frame_start !== 1'b0 || bus0.frame_done !== 1'b0 || bus0.frame_ok !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_frame: got start=%b done=%b ok=%b required 0", bus0.frame_start,
                     bus0.frame_done, bus0.frame_ok);
        end
        n_cmp++;
        if (bus0.err_odd !== 1'b0 || bus0.err_size !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err: got odd=%b size=%b required 0", bus0.err_odd, bus0.err_size);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic_frame();
        b = 8'h12;
        start_frame(1'b1, 1'b1);
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        end_frame("basic", 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus0.pix_x !== 10'd3 || bus0.pix_y !== 10'd1) begin
            n_bad++;
            $display("FAIL basic_xy_hold: got %0d/%0d required 3/1", bus0.pix_x, bus0.pix_y);
        end
    endtask

    task automatic test_simul_end();
        start_frame(1'b1, 1'b1);
        send_line(8, 1'b0);
        send_line(8, 1'b1);
        end_frame("simul", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_odd_line();
        start_frame(1'b1, 1'b1);
        send_line(9, 1'b0);
        send_line(8, 1'b0);
        end_frame("odd", 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        start_frame(1'b1, 1'b1);
        send_line(12, 1'b0);
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        end_frame("ovf", 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        int s;
        start_frame(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) drive_byte(k);
        tick();
        rst = 1'b1;
        bus0.cmos_data = b;
        m_cap = 1'b0;
        s = n_fdone;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus0.cmos_href = ~bus0.cmos_href;
            bus0.cmos_data = bus0.cmos_data + 8'h11;
        end
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            bus0.cmos_href = ~bus0.cmos_href;
            bus0.cmos_data = bus0.cmos_data + 8'h11;
        end
        bus0.cmos_href = 1'b0;
        idle(3);
        n_cmp++;
        if (n_fdone != s) begin
            n_bad++;
            $display("FAIL rstmid_no_done: got %0d frame_done pulses required 0", n_fdone - s);
        end
        n_cmp++;
        if (q0.size() != 0) begin
            n_bad++;
            $display("FAIL rstmid_pending: got %0d pixels outstanding required 0", q0.size());
        end
        q0.delete();
        q1.delete();
        start_frame(1'b1, 1'b1);
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        end_frame("rstmid", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_cap_en();
        start_frame(1'b0, 1'b0);
        send_line(8, 1'b0);
        send_line(8, 1'b0);
        end_frame("capoff", 1'b0, 1'b0, 1'b0, 1'b0);
        start_frame(1'b1, 1'b1);
        send_line(8, 1'b0);
        bus0.cap_en = 1'b0;
        send_line(8, 1'b0);
        end_frame("capon", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        b = 8'h12;
        prev = 8'h00;
        m_y = 0;
        m_cap = 1'b0;
        test_reset();
        test_basic_frame();
        test_simul_end();
        test_odd_line();
        test_overflow();
        test_reset_midframe();
        test_cap_en();
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
